// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_types (package)
// Brief    : Shared state encoding and default widths for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arbiter_types;

    localparam int c_DEFAULT_LINE_WIDTH = 256;
    localparam int c_DEFAULT_ADDR_WIDTH = 32;

    // Grant FSM: idle, instruction side owns the port, data side owns the port
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_ctr
// Brief    : Saturating counter of consecutive D grants taken while I waits.
//            Only instantiated when ARB_STARVE_GUARD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_ctr #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int                c_CW    = $clog2(LIMIT + 1);
    localparam logic [c_CW-1:0]   c_LIMIT = c_CW'(LIMIT);

    logic [c_CW-1:0] r_count;

    // Clear wins over increment; the count holds once it reaches LIMIT
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign at_limit = (r_count == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one physical-memory port between the I-cache and D-cache
//            miss ports. One owner per transaction, D wins ties, no
//            preemption. Optional starvation guard (macro ARB_STARVE_GUARD_EN)
//            forces an I grant after STARVE_LIMIT consecutive D grants
//            taken while I was waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_WIDTH   = c_DEFAULT_LINE_WIDTH,
    parameter int ADDR_WIDTH   = c_DEFAULT_ADDR_WIDTH
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_pmem_read,
    input  logic                  i_pmem_write,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    input  logic [LINE_WIDTH-1:0] i_pmem_wdata,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic w_i_req;
    logic w_d_req;
    logic w_force_i;

    assign w_i_req = i_pmem_read | i_pmem_write;
    assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_STARVE_GUARD_EN
    logic w_ctr_inc;
    logic w_ctr_clr;
    logic w_at_limit;

    // Count D grants that bypass a waiting I; clear once I gets in or stops asking
    assign w_ctr_inc = (r_state == ARB_IDLE) && (w_state_next == ARB_D) && w_i_req;
    assign w_ctr_clr = (r_state == ARB_IDLE) && ((w_state_next == ARB_I) || !w_i_req);
    assign w_force_i = w_at_limit && w_i_req;

    arb_starve_ctr #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_ctr_inc),
        .clr      (w_ctr_clr),
        .at_limit (w_at_limit)
    );
`else
    assign w_force_i = 1'b0;
`endif

    // Grant state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state selection and downstream/upstream routing for the current owner
    always_comb begin
        w_state_next = r_state;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_rdata = '0;
        d_pmem_rdata = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;

        case (r_state)
            ARB_IDLE: begin
                if (w_d_req && !w_force_i) begin
                    w_state_next = ARB_D;
                end else if (w_i_req) begin
                    w_state_next = ARB_I;
                end
            end
            ARB_I: begin
                pmem_read    = i_pmem_read;
                pmem_write   = i_pmem_write;
                pmem_address = i_pmem_address;
                pmem_wdata   = i_pmem_wdata;
                i_pmem_rdata = pmem_rdata;
                d_pmem_rdata = pmem_rdata;
                i_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    w_state_next = ARB_IDLE;
                end
            end
            ARB_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                i_pmem_rdata = pmem_rdata;
                d_pmem_rdata = pmem_rdata;
                d_pmem_resp  = pmem_resp;
                if (pmem_resp) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter. A transaction-level
//            owner model predicts every output each cycle; directed scenarios
//            plus a randomized traffic phase. Honours ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int LW     = 256;
    localparam int AW     = 32;
    localparam int LIMIT  = 4;
    localparam int G_NONE = 0;
    localparam int G_I    = 1;
    localparam int G_D    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read, i_pmem_write, i_pmem_resp;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_wdata, i_pmem_rdata;
    logic          d_pmem_read, d_pmem_write, d_pmem_resp;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata, d_pmem_rdata;
    logic          pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;

    mem_port_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    int            n_total = 0;
    int            n_bad   = 0;
    int            cyc     = 0;
    int            owner   = G_NONE;   // model: who holds the port this cycle
    int            streak  = 0;        // model: D grants taken while I waited
    bit            i_done, d_done;
    int            dn_cnt  = 0;
    int            dn_lat  = 1;
    bit            dn_rand = 0;
    bit            rdata_fixed = 0;
    logic [LW-1:0] rdata_pat = '0;
    bit            rand_mode = 0;
    bit            d_b2b     = 0;
    int            n_i_resp_dut = 0, n_d_resp_dut = 0;
    int            n_i_resp_exp = 0, n_d_resp_exp = 0;
    int            resp_q[$];          // DUT-observed resp sides in order
    int            resp_cyc_q[$];
    int            start_q[$];         // DUT-observed cycles where a downstream request rises
    bit            prev_act = 0;
    bit            i_held = 0, d_held = 0, viol = 0;
    logic [AW-1:0] i_held_addr, d_held_addr;
    logic [LW-1:0] i_held_wd, d_held_wd;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Requester-side protocol watch: payload must not move while a request is held
    task automatic monitor();
        if (d_pmem_read | d_pmem_write) begin
            if (!d_held) begin
                d_held = 1; d_held_addr = d_pmem_address; d_held_wd = d_pmem_wdata;
            end else if (d_pmem_address !== d_held_addr || d_pmem_wdata !== d_held_wd) begin
                if (!viol) $display("note: D payload changed while its request was held (protocol violation)");
                viol = 1; d_held_addr = d_pmem_address; d_held_wd = d_pmem_wdata;
            end
        end else d_held = 0;
        if (i_pmem_read | i_pmem_write) begin
            if (!i_held) begin
                i_held = 1; i_held_addr = i_pmem_address; i_held_wd = i_pmem_wdata;
            end else if (i_pmem_address !== i_held_addr || i_pmem_wdata !== i_held_wd) begin
                if (!viol) $display("note: I payload changed while its request was held (protocol violation)");
                viol = 1; i_held_addr = i_pmem_address; i_held_wd = i_pmem_wdata;
            end
        end else i_held = 0;
        if (d_done) d_held = 0;
        if (i_done) i_held = 0;
    endtask

    // One clock: check outputs mid-cycle, advance the model, then drive downstream
    task automatic tick();
        logic          e_rd, e_wr, e_ir, e_dr;
        logic [AW-1:0] e_a;
        logic [LW-1:0] e_wd, e_irdat, e_drdat;
        bit            ireq, dreq, starved;
        int            nxt;
        @(negedge clk);
        cyc++;
        e_rd = 0; e_wr = 0; e_ir = 0; e_dr = 0; e_a = '0; e_wd = '0; e_irdat = '0; e_drdat = '0;
        if (owner == G_I) begin
            e_rd = i_pmem_read; e_wr = i_pmem_write; e_a = i_pmem_address; e_wd = i_pmem_wdata;
            e_ir = pmem_resp; e_irdat = pmem_rdata; e_drdat = pmem_rdata;
        end else if (owner == G_D) begin
            e_rd = d_pmem_read; e_wr = d_pmem_write; e_a = d_pmem_address; e_wd = d_pmem_wdata;
            e_dr = pmem_resp; e_irdat = pmem_rdata; e_drdat = pmem_rdata;
        end
        check("ctl{rd,wr,iresp,dresp}", {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}, {e_rd, e_wr, e_ir, e_dr});
        check("pmem_address", pmem_address, e_a);
        check("pmem_wdata", pmem_wdata, e_wd);
        check("i_pmem_rdata", i_pmem_rdata, e_irdat);
        check("d_pmem_rdata", d_pmem_rdata, e_drdat);

        if (i_pmem_resp === 1'b1) begin n_i_resp_dut++; resp_q.push_back(G_I); resp_cyc_q.push_back(cyc); end
        if (d_pmem_resp === 1'b1) begin n_d_resp_dut++; resp_q.push_back(G_D); resp_cyc_q.push_back(cyc); end
        if ((pmem_read | pmem_write) === 1'b1 && !prev_act) start_q.push_back(cyc);
        prev_act = ((pmem_read | pmem_write) === 1'b1);

        i_done = (owner == G_I) && pmem_resp;
        d_done = (owner == G_D) && pmem_resp;
        if (i_done) n_i_resp_exp++;
        if (d_done) n_d_resp_exp++;
        monitor();

        ireq = i_pmem_read | i_pmem_write;
        dreq = d_pmem_read | d_pmem_write;
`ifdef ARB_STARVE_GUARD_EN
        starved = ireq && (streak == LIMIT);
`else
        starved = 0;
`endif
        if (rst) begin
            nxt = G_NONE; streak = 0;
        end else if (owner != G_NONE) begin
            nxt = pmem_resp ? G_NONE : owner;
        end else if (dreq && !starved) begin
            nxt = G_D;
            if (ireq && streak < LIMIT) streak++;
        end else if (ireq) begin
            nxt = G_I; streak = 0;
        end else begin
            nxt = G_NONE; streak = 0;
        end

        @(posedge clk);
        #1;
        owner = nxt;
        if (owner != G_NONE) begin
            if (dn_cnt == 0 && dn_rand) dn_lat = $urandom_range(0, 4);
            pmem_resp = (dn_cnt == dn_lat);
            dn_cnt++;
        end else begin
            dn_cnt = 0; pmem_resp = 1'b0;
        end
        pmem_rdata = rdata_fixed ? rdata_pat : rnd_line();
    endtask

    // Requesters drop on resp (or reissue at once in back-to-back mode); optional random traffic
    task automatic requesters();
        if (i_done) begin
            i_pmem_read = 0; i_pmem_write = 0;
        end else if (rand_mode && !(i_pmem_read | i_pmem_write) && $urandom_range(0, 2) == 0) begin
            i_pmem_write = ($urandom_range(0, 7) == 0); i_pmem_read = !i_pmem_write;
            i_pmem_address = $urandom; i_pmem_wdata = rnd_line();
        end
        if (d_done) begin
            if (d_b2b) d_pmem_address = d_pmem_address + 32'h40;
            else begin d_pmem_read = 0; d_pmem_write = 0; end
        end else if (rand_mode && !(d_pmem_read | d_pmem_write) && $urandom_range(0, 1) == 0) begin
            d_pmem_write = ($urandom_range(0, 2) == 0); d_pmem_read = !d_pmem_write;
            d_pmem_address = $urandom; d_pmem_wdata = rnd_line();
        end
    endtask

    task automatic step();
        tick();
        requesters();
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int n = 0;
        while ((owner != G_NONE || i_pmem_read || i_pmem_write || d_pmem_read || d_pmem_write) && n < budget) begin
            step(); n++;
        end
        check(tag, (n < budget), 1'b1);
    endtask

    initial begin
        int b, s, bi, bd;
        int want_seq[6];

        // Reset held two cycles with both sides requesting
        rst = 1; pmem_resp = 0; pmem_rdata = '0;
        i_pmem_read = 1; i_pmem_write = 0; i_pmem_address = 32'h111; i_pmem_wdata = '0;
        d_pmem_read = 1; d_pmem_write = 0; d_pmem_address = 32'h222; d_pmem_wdata = '0;
        @(posedge clk); #1;
        tick(); tick();
        rst = 0;
        dn_lat = 1;
        b = resp_q.size();
        run_until_idle(50, "after_reset_drain");
        check("after_reset_first_served", resp_q[b], G_D);
        check("after_reset_second_served", resp_q[b+1], G_I);

        // Lone I read, 5-cycle downstream latency, fixed pattern A
        rdata_fixed = 1; rdata_pat = {8{32'hA5A5_1234}};
        dn_lat = 5; bi = n_i_resp_dut; bd = n_d_resp_dut;
        i_pmem_read = 1; i_pmem_address = 32'h0000_1040;
        run_until_idle(50, "lone_i_drain");
        check("lone_i_resp_count", n_i_resp_dut - bi, 1);
        check("lone_i_d_resp_count", n_d_resp_dut - bd, 0);
        check("lone_i_latency", resp_cyc_q[resp_cyc_q.size()-1] - start_q[start_q.size()-1], 5);

        // Simultaneous I read and D write: D first, one idle cycle, then I
        rdata_fixed = 0; dn_lat = 2;
        b = resp_q.size(); s = start_q.size();
        i_pmem_read = 1; i_pmem_address = 32'h100;
        d_pmem_write = 1; d_pmem_address = 32'h200; d_pmem_wdata = {32{8'hA5}};
        run_until_idle(50, "tie_drain");
        check("tie_first", resp_q[b], G_D);
        check("tie_second", resp_q[b+1], G_I);
        check("tie_regrant_gap", start_q[s+1] - resp_cyc_q[b], 2);

        // Reset two cycles into a D write: no resp, port quiet afterwards
        dn_lat = 10; bd = n_d_resp_dut;
        d_pmem_write = 1; d_pmem_address = 32'h300;
        step(); step(); step();
        rst = 1; step();
        rst = 0; d_pmem_write = 0;
        step(); step();
        check("reset_mid_no_d_resp", n_d_resp_dut - bd, 0);
        run_until_idle(20, "reset_mid_drain");

        // Continuous D traffic with I holding a read
        step(); step();
        dn_lat = 0; d_b2b = 1; b = resp_q.size();
        d_pmem_read = 1; d_pmem_address = 32'h4000;
        i_pmem_read = 1; i_pmem_address = 32'h8000;
        begin
            int n = 0;
            while (resp_q.size() < b + 6 && n < 300) begin step(); n++; end
            check("starve_window", (n < 300), 1'b1);
        end
`ifdef ARB_STARVE_GUARD_EN
        want_seq = '{G_D, G_D, G_D, G_D, G_I, G_D};
`else
        want_seq = '{G_D, G_D, G_D, G_D, G_D, G_D};
`endif
        for (int j = 0; j < 6; j++) check($sformatf("starve_seq[%0d]", j), resp_q[b+j], want_seq[j]);
        d_b2b = 0;
        run_until_idle(100, "starve_drain");

        // Randomized traffic
        check("viol_before_random", viol, 1'b0);
        rand_mode = 1; dn_rand = 1;
        repeat (400) step();
        rand_mode = 0;
        run_until_idle(300, "random_drain");
        dn_rand = 0;
        check("random_i_resp_total", n_i_resp_dut, n_i_resp_exp);
        check("random_d_resp_total", n_d_resp_dut, n_d_resp_exp);
        check("viol_after_random", viol, 1'b0);

        // Protocol violation: D address moves mid-grant, port tracks it combinationally
        dn_lat = 6;
        d_pmem_read = 1; d_pmem_write = 0; d_pmem_address = 32'h500;
        step(); step(); step();
        d_pmem_address = 32'h504;
        run_until_idle(30, "violation_drain");
        check("violation_flagged", viol, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the pipelined core's split instruction-cache and data-cache miss ports onto the single shared physical-memory port (cacheline adapter / L2). Exactly one requester owns the downstream port per transaction, tracked by a small grant FSM. Data-side requests win ties. An optional starvation guard bounds how long instruction fetch can be locked out.

## Interface
- LINE_WIDTH, 256, cacheline width in bits
- ADDR_WIDTH, 32, line address width
- STARVE_LIMIT, 4, consecutive D grants tolerated while I waits (guard build only)

Ports. Clock and reset are decided: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line read request
- i_pmem_write  in  1  I-cache line write request (forwarded, normally 0)
- i_pmem_address  in  ADDR_WIDTH  I-side line address
- i_pmem_wdata  in  LINE_WIDTH  I-side write line
- i_pmem_rdata  out  LINE_WIDTH  read line to I-cache
- i_pmem_resp  out  1  transaction done, I side
- d_pmem_read / d_pmem_write / d_pmem_address / d_pmem_wdata  in  as I side  D-cache request
- d_pmem_rdata  out  LINE_WIDTH; d_pmem_resp  out  1  D-side return
- pmem_read, pmem_write  out  1  downstream request
- pmem_address  out  ADDR_WIDTH; pmem_wdata  out  LINE_WIDTH  downstream request payload
- pmem_rdata  in  LINE_WIDTH; pmem_resp  in  1  downstream return

## Operation
- FSM states: ARB_IDLE, ARB_I, ARB_D. Reset state is ARB_IDLE.
- ARB_IDLE:
  - All pmem_* outputs are 0. Both *_pmem_resp are 0.
  - d_req = d_read|d_write; i_req = i_read|i_write.
  - d_req goes to ARB_D. Else i_req goes to ARB_I. Else stay.
- ARB_I / ARB_D:
  - pmem_read, pmem_write, pmem_address and pmem_wdata are muxed combinationally from the granted requester.
  - pmem_rdata is driven to both *_pmem_rdata.
  - pmem_resp is routed only to the granted side's resp. The other side's resp stays 0.
  - On pmem_resp=1 the FSM returns to ARB_IDLE.
- Requester protocol: hold the request and payload stable from assertion until its resp. Drop the request the cycle after resp. Read and write together from one requester is illegal; the arbiter forwards it unchanged.
- The arbiter never preempts a granted transaction.
- A request that arrives while the other side is granted waits. It is not lost, because the requester holds it.
- Reset mid-transaction: the FSM returns to ARB_IDLE, the counter clears, and no resp is generated. Any downstream handshake in flight is abandoned; the downstream port is reset by the same rst.

## Timing
- Request seen in ARB_IDLE at cycle t: pmem_read/pmem_write asserted at t+1.
- Arbitration overhead: 1 cycle.
- pmem_resp at cycle r: granted *_pmem_resp=1 at r, with zero added latency. FSM is in ARB_IDLE at r+1.
- Earliest next grant is r+2. This guarantees pmem_read is low for at least one cycle between transactions.
- Back-to-back same-side requests: the same r+2 spacing applies.
- Simultaneous i_req and d_req in ARB_IDLE: D is granted, unless the starvation guard forces I (see Configuration).
- All outputs are 0 the cycle after reset.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments on each entry to ARB_D while i_req is high.
  - The counter clears on entry to ARB_I, or when i_req is low in ARB_IDLE.
  - When the counter equals STARVE_LIMIT and i_req=1 in ARB_IDLE, I is granted even if d_req=1.
  - The counter saturates and does not wrap.
- Undefined: strict D priority. No counter logic is compiled in.

## Structure
- Shared package arbiter_types holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_I, ARB_D}
  - localparams for default LINE_WIDTH and ADDR_WIDTH
- Sub-module arb_starve_ctr (saturating counter, inputs inc/clr, output at_limit) is instantiated only under ARB_STARVE_GUARD_EN.
- Otherwise this is one flat module: FSM register, next-state logic, output mux.

## Test plan
- Reset: hold rst for 2 cycles with both requests high. Required: all pmem_* and *_resp are 0. Grant goes to D at the cycle after rst falls +1.
- Lone I read, addr 0x0000_1040, downstream resp after 5 cycles:
  - Required: pmem_read=1 and pmem_address=0x0000_1040 from t+1.
  - i_pmem_resp pulses once with rdata=pattern A.
  - d_pmem_resp stays 0.
- Simultaneous I read 0x100 and D write 0x200 (wdata=all 0xA5):
  - Required: D is served first; pmem_write=1, address 0x200.
  - After D's resp, one idle cycle, then I is granted with address 0x100.
- Reset asserted 2 cycles into a D transaction. Required: FSM returns to ARB_IDLE, pmem_write=0 next cycle, no d_pmem_resp.
- Guard build, STARVE_LIMIT=4: D requests continuously and I holds a read.
  - Required: exactly 4 D grants, then an I grant, then D resumes.
  - Without the macro: I is never granted while D keeps requesting.
- Payload stability: change d_pmem_address mid-grant (protocol violation injected). Required: pmem_address tracks the input combinationally (documented behaviour). The bench assertion flags the violation.
